lgn_frame_tx: RTL
=================

Name: lgn_frame_tx

Overview:
- Transmit end of the classifier's 8-bit input shift interface.
- Accepts a binarized 16x16 image as a 1-pixel-per-cycle valid/ready stream and packs it MSB-first into 32 bytes.
- Drives the bytes with a write strobe into the 256-bit input shift register, then waits for the gate network and argmax to settle.
- Captures the winning category index and value, and presents them on a valid/ready result port.

Parameters:
- PIXELS, 256, pixels per frame; must be a multiple of 8.
- SETTLE_CYCLES, 2, cycles between the last byte strobe and result capture; minimum 1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel available.
- pix_ready  out  1  block accepts a pixel this cycle.
- pix_data  in  1  binarized pixel.
- pix_last  in  1  marks the final pixel of a frame.
- tx_data  out  8  byte to the classifier input; pixel 8k+0 is on bit 7.
- tx_we  out  1  one-cycle byte write strobe; the receiver shifts tx_data in on the same edge.
- res_index  in  4  classifier best category index (combinational).
- res_value  in  8  classifier best category value (combinational).
- out_valid  out  1  captured result available.
- out_ready  in  1  consumer takes the result.
- out_index  out  4  captured index.
- out_value  out  8  captured value.
- frame_err  out  1  one-cycle pulse on a pix_last/count mismatch.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: pix_ready=0, tx_data=0, tx_we=0, out_valid=0, out_index=0, out_value=0, frame_err=0, busy=0. All counters clear and the state is IDLE.
- A pixel is accepted when pix_valid and pix_ready are both high at a rising edge.
- Pixel p lands at receiver bit PIXELS-1-p.
- States: IDLE, FILL, PAD, SETTLE, HOLD.
- IDLE: pix_ready=1. The first accepted pixel moves the block to FILL and counts as pixel 0.
- FILL:
  - pix_ready=1. Each pixel shifts into an 8-bit pack register and increments pix_cnt (0..PIXELS-1).
  - When the 8th bit of a byte is accepted at edge E, tx_data/tx_we are registered at E, so tx_we is high in the cycle after E.
  - Back-to-back pixels are allowed, so the strobe can fire every 8 cycles with no bubbles.
- Accepting pixel PIXELS-1:
  - pix_ready drops to 0 on the next cycle.
  - The state goes to SETTLE, entered together with the final tx_we cycle.
  - If pix_last was not high on that pixel, frame_err pulses.
- pix_last high on pixel p < PIXELS-1:
  - frame_err pulses and the current partial byte is zero-filled and emitted.
  - The state goes to PAD, where pix_ready=0 and zero bytes are emitted, one tx_we per cycle, until 32 bytes total have been sent. The state then goes to SETTLE.
- SETTLE:
  - A counter starts at 0 in the cycle holding the final tx_we.
  - The result is sampled at the edge ending the SETTLE_CYCLES-th cycle after that one.
  - out_valid rises the next cycle and the state goes to HOLD.
- HOLD: out_index/out_value are stable while out_valid=1. At out_valid&out_ready the block clears out_valid and returns to IDLE; pix_ready=1 from the next cycle.
- Only one frame is in flight. pix_ready=0 in PAD, SETTLE and HOLD.
- tx_we is never high outside FILL/PAD or the final-byte cycle. Exactly 32 strobes are issued per frame.
- Reset mid-frame: asynchronous clear as above and the partial frame is discarded. The receiver shift register is not cleared; the next frame overwrites all 256 bits.
- out_value is captured at the full 8-bit width of res_value; no arithmetic is applied.

Test Plan:
- Reset mid-FILL after 100 pixels -> all outputs 0 at once, busy=0. The next full frame yields exactly 32 tx_we pulses.
- Frame of pixels all 1, continuous valid, pix_last on pixel 255:
  - tx_data=0xFF on 32 strobes at 8-cycle spacing, first strobe 1 cycle after pixel 7.
  - out_valid exactly SETTLE_CYCLES+1 cycles after the last strobe.
  - frame_err=0.
- Pixel pattern p%8==0 set:
  - every byte equals 0x80.
  - A behavioural shift model gives a 256-bit register of 0x8080..80.
  - Stubbed res_index=7, res_value=0x2A are captured as 7/0x2A.
- pix_last on pixel 12:
  - byte 1 = pixels 8..12 then 000.
  - 30 further 0x00 strobes in consecutive cycles.
  - one frame_err pulse; result still produced.
- No pix_last on pixel 255 -> frame_err pulses once, result produced normally.
- out_ready held low 20 cycles in HOLD:
  - out_valid and out_index/out_value stay stable and pix_ready=0.
  - Asserting out_ready returns the block to IDLE and pix_ready=1 on the following cycle.
- Random pix_valid gaps, about 50% duty:
  - packed bytes match the pixel order.
  - No strobe occurs without a completed byte.

Source files
------------

// File: rtl/lgn_frame_tx.sv
// Packs a 1-pixel-per-cycle binarized frame into bytes for the classifier's
// input shift register, then captures the settled argmax result.
module lgn_frame_tx #(
  parameter int PIXELS        = 256,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic       pix_data,
  input  logic       pix_last,
  output logic [7:0] tx_data,
  output logic       tx_we,
  input  logic [3:0] res_index,
  input  logic [7:0] res_value,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_index,
  output logic [7:0] out_value,
  output logic       frame_err,
  output logic       busy
);

  localparam int NBYTES = PIXELS / 8;
  localparam int CW     = $clog2(PIXELS);
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int SW     = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, FILL, PAD, SETTLE, HOLD} state_t;

  state_t        state_reg;
  logic [CW-1:0] pix_cnt_reg;
  logic [6:0]    pack_reg;
  logic [BW-1:0] byte_cnt_reg;
  logic [SW-1:0] settle_cnt_reg;

  logic          accept;
  logic          last_pix;
  logic [7:0]    byte_full;
  logic [7:0]    byte_padded;
  logic [BW-1:0] byte_idx;

  assign accept      = pix_valid & pix_ready;
  assign last_pix    = (pix_cnt_reg == CW'(PIXELS - 1));
  assign byte_full   = {pack_reg, pix_data};
  // Early pix_last: left-align the partial byte so the missing pixels read as zero.
  assign byte_padded = byte_full << (3'd7 - pix_cnt_reg[2:0]);
  assign byte_idx    = BW'(pix_cnt_reg >> 3);
  assign busy        = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pix_cnt_reg    <= '0;
      pack_reg       <= '0;
      byte_cnt_reg   <= '0;
      settle_cnt_reg <= '0;
      pix_ready      <= 1'b0;
      tx_data        <= '0;
      tx_we          <= 1'b0;
      out_valid      <= 1'b0;
      out_index      <= '0;
      out_value      <= '0;
      frame_err      <= 1'b0;
    end else begin
      tx_we     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_reg)
        IDLE, FILL: begin
          pix_ready <= 1'b1;
          if (accept) begin
            state_reg   <= FILL;
            pack_reg    <= byte_full[6:0];
            pix_cnt_reg <= pix_cnt_reg + 1'b1;
            if (last_pix) begin
              tx_data        <= byte_full;
              tx_we          <= 1'b1;
              pix_ready      <= 1'b0;
              frame_err      <= ~pix_last;
              settle_cnt_reg <= '0;
              state_reg      <= SETTLE;
            end else if (pix_last) begin
              tx_data        <= byte_padded;
              tx_we          <= 1'b1;
              pix_ready      <= 1'b0;
              frame_err      <= 1'b1;
              byte_cnt_reg   <= byte_idx + 1'b1;
              settle_cnt_reg <= '0;
              state_reg      <= (byte_idx == BW'(NBYTES - 1)) ? SETTLE : PAD;
            end else if (pix_cnt_reg[2:0] == 3'd7) begin
              tx_data <= byte_full;
              tx_we   <= 1'b1;
            end
          end
        end
        PAD: begin
          // byte_cnt_reg counts bytes already strobed; this cycle emits one more.
          tx_data      <= '0;
          tx_we        <= 1'b1;
          byte_cnt_reg <= byte_cnt_reg + 1'b1;
          if (byte_cnt_reg == BW'(NBYTES - 1)) begin
            settle_cnt_reg <= '0;
            state_reg      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == SW'(SETTLE_CYCLES)) begin
            out_index <= res_index;
            out_value <= res_value;
            out_valid <= 1'b1;
            state_reg <= HOLD;
          end else begin
            settle_cnt_reg <= settle_cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            pix_ready   <= 1'b1;
            pix_cnt_reg <= '0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
